// File: rtl/instr_dispatch.sv
// Instruction dispatcher: fetches one 16-bit word per instruction, broadcasts it to
// the execution FSMs while in EXEC, and owns the program counter.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// FETCH  | mem_req high at pc, waiting for mem_valid
// EXEC   | instr = IR, cycle counter running, pc_inc/pc_load honoured
// HALT   | opcode 0 fetched, pc left on the halt word
// FAULT  | illegal opcode or EXEC timeout, cause in fault_code
module instr_dispatch #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       instr,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  logic              exec_done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [15:0] IDLE_OP = 16'hF000;
    localparam logic [1:0]  FC_NONE    = 2'b00;
    localparam logic [1:0]  FC_ILLEGAL = 2'b01;
    localparam logic [1:0]  FC_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            state;
    logic [15:0]       ir;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        fcode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ir    <= '0;
            pc_q  <= '0;
            cnt   <= '0;
            fcode <= FC_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_valid) begin
                        ir <= mem_rdata;
                        case (mem_rdata[15:12])
                            4'h0: state <= S_HALT;
                            4'hF: begin
                                state <= S_FAULT;
                                fcode <= FC_ILLEGAL;
                            end
                            default: begin
                                state <= S_EXEC;
                                cnt   <= '0;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    // pc update is independent of exec_done so the next fetch sees it
                    if (pc_load)
                        pc_q <= pc_load_val;
                    else if (pc_inc)
                        pc_q <= pc_q + ADDR_W'(1);

                    if (exec_done) begin
                        state <= S_FETCH;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_FAULT;
                        fcode <= FC_TIMEOUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HALT: begin
                    if (start)
                        state <= S_FETCH;
                end
                S_FAULT: begin
                    if (start) begin
                        state <= S_FETCH;
                        fcode <= FC_NONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; FETCH always separates two EXECs,
    // so the idle opcode appears between consecutive instructions.
    assign instr      = (state == S_EXEC) ? ir : IDLE_OP;
    assign mem_req    = (state == S_FETCH);
    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign busy       = (state == S_FETCH) || (state == S_EXEC);
    assign halted     = (state == S_HALT);
    assign fault      = (state == S_FAULT);
    assign fault_code = fcode;

endmodule

// File: tb/tb_instr_dispatch.sv
// Scoreboard bench for instr_dispatch: stimulus queues expected fetch / exec-end /
// halt / fault events, a negedge monitor pops and compares them as they occur.
module tb_instr_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] instr;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic        exec_done;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;

    instr_dispatch #(.ADDR_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .instr(instr), .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .exec_done(exec_done), .pc(pc), .busy(busy), .halted(halted), .fault(fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    localparam int EV_FETCH = 0;
    localparam int EV_EXEC  = 1;
    localparam int EV_HALT  = 2;
    localparam int EV_FAULT = 3;

    typedef struct {
        int          kind;
        logic [7:0]  a;
        logic [15:0] ins;
        int          len;
        logic [1:0]  code;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_ev(input int kind, input logic [7:0] a, input logic [15:0] ins,
                           input int len, input logic [1:0] code);
        ev_t e;
        e.kind = kind; e.a = a; e.ins = ins; e.len = len; e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic pop_ev(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)", kind, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            ok = 1'b1;
        end
    endtask

    // Memory model: answers one cycle after mem_req is first seen.
    initial begin
        bit seen;
        seen      = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_valid = 1'b0;
                seen      = 1'b0;
            end else if (mem_valid) begin
                mem_valid = 1'b0;
            end else if (mem_req && seen) begin
                mem_valid = 1'b1;
                mem_rdata = mem[mem_addr];
                seen      = 1'b0;
            end else if (mem_req) begin
                seen = 1'b1;
            end
        end
    end

    // Monitor: event order within one sample is exec-end, fetch, halt, fault.
    initial begin
        logic        p_req, p_halt, p_fault;
        int          run;
        logic [15:0] cur_ins;
        ev_t         e;
        bit          ok;
        p_req = 1'b0; p_halt = 1'b0; p_fault = 1'b0; run = 0; cur_ins = 16'h0;
        forever begin
            @(negedge clk);
            if (instr !== 16'hF000) begin
                run++;
                cur_ins = instr;
            end else if (run > 0) begin
                pop_ev(EV_EXEC, e, ok);
                if (ok) begin
                    check("exec_instr", cur_ins, e.ins);
                    check("exec_len", run, e.len);
                    check("exec_pc_after", pc, e.a);
                end
                run = 0;
            end
            if (mem_req && !p_req) begin
                pop_ev(EV_FETCH, e, ok);
                if (ok) begin
                    check("fetch_addr", mem_addr, e.a);
                    check("fetch_fault_code", fault_code, 2'b00);
                end
            end
            if (halted && !p_halt) begin
                pop_ev(EV_HALT, e, ok);
                if (ok) begin
                    check("halt_pc", pc, e.a);
                    check("halt_busy", busy, 1'b0);
                end
            end
            if (fault && !p_fault) begin
                pop_ev(EV_FAULT, e, ok);
                if (ok) begin
                    check("fault_pc", pc, e.a);
                    check("fault_code", fault_code, e.code);
                    check("fault_instr", instr, 16'hF000);
                end
            end
            p_req = mem_req; p_halt = halted; p_fault = fault;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, mem_req, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_halted"}, halted, 1'b0);
        check({tag, "_fault"}, fault, 1'b0);
        check({tag, "_fault_code"}, fault_code, 2'b00);
        check({tag, "_pc"}, pc, 8'h00);
        check({tag, "_instr"}, instr, 16'hF000);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_exec(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (instr !== 16'hF000) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL exec_wait: instr stayed %0h, expected an EXEC period", instr);
        end
    endtask

    // Drives strobes for EXEC cycles 1..ncyc; a cycle index of 0 means never.
    task automatic run_exec(input int inc_c, input int load_c, input logic [7:0] load_v,
                            input int done_c, input int ncyc);
        bit ok;
        wait_exec(ok);
        if (ok) begin
            for (int c = 1; c <= ncyc; c++) begin
                pc_inc      = (c == inc_c);
                pc_load     = (c == load_c);
                pc_load_val = load_v;
                exec_done   = (c == done_c);
                @(negedge clk);
            end
        end
        pc_inc = 1'b0; pc_load = 1'b0; exec_done = 1'b0; pc_load_val = 8'h00;
    endtask

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0;
        pc_inc = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00; exec_done = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h6082;
        mem[1]   = 16'h0000;
        mem[255] = 16'h2000;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_mem_addr", mem_addr, 8'h00);
        @(posedge clk); #1 rst = 1'b0;

        // MOV at 0: pc_inc in cycle 2, done in cycle 4, then halt word at 1
        push_ev(EV_FETCH, 8'h00, 16'h0, 0, 2'b00);
        push_ev(EV_EXEC,  8'h01, 16'h6082, 4, 2'b00);
        push_ev(EV_FETCH, 8'h01, 16'h0, 0, 2'b00);
        push_ev(EV_HALT,  8'h01, 16'h0, 0, 2'b00);
        pulse_start();
        run_exec(2, 0, 8'h00, 4, 4);
        repeat (6) @(negedge clk);

        // restart from HALT refetches the same word
        push_ev(EV_FETCH, 8'h01, 16'h0, 0, 2'b00);
        push_ev(EV_HALT,  8'h01, 16'h0, 0, 2'b00);
        pulse_start();
        repeat (6) @(negedge clk);

        // illegal opcode
        mem[1] = 16'hF123;
        push_ev(EV_FETCH, 8'h01, 16'h0, 0, 2'b00);
        push_ev(EV_FAULT, 8'h01, 16'h0, 0, 2'b01);
        pulse_start();
        repeat (6) @(negedge clk);

        // timeout: no exec_done for 15 cycles
        mem[1] = 16'h3000;
        push_ev(EV_FETCH, 8'h01, 16'h0, 0, 2'b00);
        push_ev(EV_EXEC,  8'h01, 16'h3000, 15, 2'b00);
        push_ev(EV_FAULT, 8'h01, 16'h0, 0, 2'b10);
        pulse_start();
        run_exec(0, 0, 8'h00, 0, 15);
        repeat (4) @(negedge clk);

        // exec_done in cycle 15 beats the timeout; then branch + wrap
        push_ev(EV_FETCH, 8'h01, 16'h0, 0, 2'b00);
        push_ev(EV_EXEC,  8'h01, 16'h3000, 15, 2'b00);
        push_ev(EV_FETCH, 8'h01, 16'h0, 0, 2'b00);
        push_ev(EV_EXEC,  8'hFF, 16'h5000, 1, 2'b00);
        push_ev(EV_FETCH, 8'hFF, 16'h0, 0, 2'b00);
        push_ev(EV_EXEC,  8'h00, 16'h2000, 3, 2'b00);
        push_ev(EV_FETCH, 8'h00, 16'h0, 0, 2'b00);
        push_ev(EV_EXEC,  8'h00, 16'h6082, 1, 2'b00);
        pulse_start();
        run_exec(0, 0, 8'h00, 15, 15);
        mem[1] = 16'h5000;
        run_exec(1, 1, 8'hFF, 1, 1);
        run_exec(1, 0, 8'h00, 3, 3);

        // reset in EXEC cycle 2 with pending strobes
        wait_exec(ok);
        @(posedge clk);
        #1 rst = 1'b1;
        pc_inc = 1'b1; exec_done = 1'b1; pc_load = 1'b1; pc_load_val = 8'h55;
        #1 check_reset_outputs("rst_exec");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_pc", pc, 8'h00);
        check("post_rst_busy", busy, 1'b0);
        pc_inc = 1'b0; exec_done = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00;

        // first start after reset fetches address 0
        mem[1] = 16'h0000;
        push_ev(EV_FETCH, 8'h00, 16'h0, 0, 2'b00);
        push_ev(EV_EXEC,  8'h01, 16'h6082, 1, 2'b00);
        push_ev(EV_FETCH, 8'h01, 16'h0, 0, 2'b00);
        push_ev(EV_HALT,  8'h01, 16'h0, 0, 2'b00);
        pulse_start();
        run_exec(1, 0, 8'h00, 1, 1);
        repeat (6) @(negedge clk);

        check("events_outstanding", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
